tmds_encoder_seq: RTL
=====================

// Module: tmds_encoder_seq
// PURPOSE
//  Sequential three-channel DVI 1.0 TMDS encoder in the clk_pixel_x10 domain; sits directly upstream of the serializer.
//  Converts one 24-bit pixel (or a control/blanking period) into three 10-bit TMDS symbols (tmds_internal0..2).
//  The encode is spread over 10 fast-clock cycles: a bit-serial transition-minimised stage, then a DC-balance stage.
//  Pixel-domain inputs are resynchronised internally.
// PARAMETERS
//  SYNC_STAGES  2  flop stages on de/ctrl/data0..2 before capture (min 2)
//  DC_BALANCE   1  1: track running disparity per channel; 0: disparity forced to 0 (cnt==0 branch always taken)
// PORTS
//  clk_pixel_x10    in   1   fast clock, 10x pixel rate
//  reset            in   1   synchronous, active-high
//  start            in   1   1-cycle strobe, once per 10 clocks; captures the synchronised inputs
//  de               in   1   data enable; 0 = control period
//  ctrl             in   2   {vsync,hsync}, channel 0 only; channels 1/2 use 2'b00
//  data0/1/2        in   8   blue/green/red pixel bytes
//  tmds_internal0/1/2  out  10  encoded symbols (bit 0 transmitted first), held between updates
//  done             out  1   1-cycle pulse, new symbols valid
//  busy             out  1   high from the capture edge until the result edge
//  overrun          out  1   sticky: start seen while busy
// BEHAVIOUR
//  Reset:
//   - state IDLE; busy=0, done=0, overrun=0; all disparity counters cnt=0
//   - tmds_internal0..2 = 10'b1101010100; synchroniser flops cleared
//  FSM IDLE -> QM -> BAL -> IDLE. Edges E0..E9 are counted from the edge at which start=1 in IDLE.
//   - E0: latch de, ctrl, data*; compute N1(D) per channel; busy<=1; bit index k<=0
//   - E1..E8 (QM): per channel build q_m[k], k=0..7, and accumulate N1(q_m[7:0]) in a 4-bit counter
//       q_m[0]=D[0]; q_m[k]=q_m[k-1] ^ D[k] (XOR mode) or ~(q_m[k-1]^D[k]) (XNOR mode)
//       XNOR mode iff N1(D)>4 or (N1(D)==4 and D[0]==0); q_m[8]=1 for XOR, 0 for XNOR
//   - E9 (BAL): register outputs; busy<=0; done=1 for the cycle following E9
//   - Earliest accepted next start is E10; latency start->done is 10 cycles
//  BAL rules, N1/N0 = ones/zeros of q_m[7:0]; cnt is signed 5-bit (range -8..+8, even values only):
//   - de=0: out = CTL(ctrl): 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011; cnt<=0
//   - cnt==0 or N1==N0:
//       out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}
//       cnt += q_m8 ? (N1-N0) : (N0-N1)
//   - (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
//       out = {1, q_m8, ~q_m[7:0]}
//       cnt += 2*q_m8 + (N0-N1)
//   - else:
//       out = {0, q_m8, q_m[7:0]}
//       cnt += (N1-N0) - 2*(~q_m8)
//  Boundary conditions:
//   - start while busy: ignored; conversion in flight completes unchanged; overrun<=1 until reset
//   - start while done=1: accepted normally (done and capture on the same edge is legal)
//   - reset mid-conversion: abort immediately; no done pulse; outputs, cnt and FSM return to reset values
//   - de is sampled only at E0; changes during QM/BAL have no effect
//   - cnt arithmetic is 5-bit signed; no saturation (the DVI rules keep |cnt|<=8)
// TESTING
//  1 reset, start with de=0, ctrl=01 -> E9: ch0=0010101011, ch1=ch2=1101010100; done pulses once; cnt=0
//  2 de=1, data0=8'h00 three times from cnt=0 -> ch0 = 0100000000 / 1111111111 / 0100000000; cnt = -8 / +2 / -6
//  3 de=1, data0=8'hFF from cnt=0 -> XNOR path, ch0=1000000000, cnt=-8
//  4 start at E0 then again at E5 -> second start ignored; overrun=1 sticky; symbols from first capture only
//  5 reset asserted at E4 -> busy=0, no done, outputs=1101010100, next conversion starts from cnt=0
//  6 random de/ctrl/data, start every 10 cycles, 10k symbols -> match golden DVI encoder model exactly

Source files
------------

// File: rtl/tmds_encoder_seq.sv
// Three-channel DVI TMDS encoder running in the 10x pixel clock domain.
// A bit-serial transition-minimising stage builds q_m over 8 cycles, then one DC-balance cycle registers the symbols.
module tmds_encoder_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          DC_BALANCE  = 1'b1
) (
  input  logic       clk_pixel_x10,
  input  logic       reset,
  input  logic       start,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [9:0] tmds_internal0,
  output logic [9:0] tmds_internal1,
  output logic [9:0] tmds_internal2,
  output logic       done,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SYNC_W = 1 + 2 + NCH * BYTE_W;

  localparam logic [SYM_W-1:0] CTL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTL_11 = 10'b1010101011;

  typedef enum logic [1:0] {S_IDLE, S_QM, S_BAL} state_t;

  state_t state_q, state_d;
  logic   capture_c, step_c, bal_c;
  logic [2:0] bit_k_q;

  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0] sync_out_c;

  logic                    de_q;
  logic [1:0]              ctrl_q;
  logic [BYTE_W-1:0]       d_q      [NCH];
  logic [BYTE_W-1:0]       qm_q     [NCH];
  logic [3:0]              n1q_q    [NCH];
  logic                    xnor_q   [NCH];
  logic signed [CNT_W-1:0] cnt_q    [NCH];
  logic [SYM_W-1:0]        tmds_q   [NCH];

  logic                    step_bit_c [NCH];
  logic                    xnor_sel_c [NCH];
  logic [SYM_W-1:0]        sym_c      [NCH];
  logic signed [CNT_W-1:0] cnt_nx_c   [NCH];

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(d[i]);
    return c;
  endfunction

  function automatic logic [SYM_W-1:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return CTL_00;
      2'b01:   return CTL_01;
      2'b10:   return CTL_10;
      default: return CTL_11;
    endcase
  endfunction

  // DC-balance decision: returns {symbol, updated disparity}
  function automatic logic [SYM_W+CNT_W-1:0] bal_step(input logic [7:0] qm, input logic qm8,
                                                      input logic [3:0] n1,
                                                      input logic signed [CNT_W-1:0] cnt);
    logic [CNT_W-1:0]        n1w;
    logic signed [CNT_W-1:0] diff;
    logic signed [CNT_W-1:0] two_q8;
    logic signed [CNT_W-1:0] two_nq8;
    logic [SYM_W-1:0]        sym;
    logic signed [CNT_W-1:0] cnt_nx;
    n1w     = {1'b0, n1};
    diff    = $signed(n1w) - $signed(5'd8 - n1w);
    two_q8  = $signed({3'b000, qm8, 1'b0});
    two_nq8 = $signed({3'b000, ~qm8, 1'b0});
    if (cnt == 5'sd0 || n1 == 4'd4) begin
      sym    = {~qm8, qm8, (qm8 ? qm : ~qm)};
      cnt_nx = qm8 ? (cnt + diff) : (cnt - diff);
    end else if ((cnt > 5'sd0 && n1 > 4'd4) || (cnt < 5'sd0 && n1 < 4'd4)) begin
      sym    = {1'b1, qm8, ~qm};
      cnt_nx = cnt + two_q8 - diff;
    end else begin
      sym    = {1'b0, qm8, qm};
      cnt_nx = cnt + diff - two_nq8;
    end
    return {sym, cnt_nx};
  endfunction

  // Input resynchroniser
  always_ff @(posedge clk_pixel_x10) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {de, ctrl, data2, data1, data0};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out_c = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_pixel_x10) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_QM;
      S_QM:    if (bit_k_q == 3'd7) state_d = S_BAL;
      S_BAL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture_c = 1'b0;
    step_c    = 1'b0;
    bal_c     = 1'b0;
    case (state_q)
      S_IDLE:  capture_c = start;
      S_QM:    step_c    = 1'b1;
      S_BAL:   bal_c     = 1'b1;
      default: ;
    endcase
  end

  // Per-channel next q_m bit, XNOR-mode selection and balance result
  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      logic [BYTE_W-1:0] din;
      logic [3:0]        n1d;
      logic [SYM_W+CNT_W-1:0] res;
      din             = sync_out_c[BYTE_W*ch +: BYTE_W];
      n1d             = popcount8(din);
      xnor_sel_c[ch]  = (n1d > 4'd4) || (n1d == 4'd4 && !din[0]);
      step_bit_c[ch]  = (bit_k_q == 3'd0) ? d_q[ch][0]
                                          : (qm_q[ch][7] ^ d_q[ch][0] ^ xnor_q[ch]);
      res             = bal_step(qm_q[ch], ~xnor_q[ch], n1q_q[ch],
                                 DC_BALANCE ? cnt_q[ch] : 5'sd0);
      sym_c[ch]       = res[CNT_W +: SYM_W];
      cnt_nx_c[ch]    = $signed(res[CNT_W-1:0]);
    end
  end

  always_ff @(posedge clk_pixel_x10) begin
    if (reset) begin
      bit_k_q <= 3'd0;
      de_q    <= 1'b0;
      ctrl_q  <= 2'b00;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        d_q[ch]    <= '0;
        qm_q[ch]   <= '0;
        n1q_q[ch]  <= '0;
        xnor_q[ch] <= 1'b0;
        cnt_q[ch]  <= '0;
        tmds_q[ch] <= CTL_00;
      end
    end else if (capture_c) begin
      bit_k_q <= 3'd0;
      de_q    <= sync_out_c[SYNC_W-1];
      ctrl_q  <= sync_out_c[SYNC_W-2 -: 2];
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        d_q[ch]    <= sync_out_c[BYTE_W*ch +: BYTE_W];
        qm_q[ch]   <= '0;
        n1q_q[ch]  <= '0;
        xnor_q[ch] <= xnor_sel_c[ch];
      end
    end else if (step_c) begin
      bit_k_q <= bit_k_q + 3'd1;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        d_q[ch]   <= d_q[ch] >> 1;
        qm_q[ch]  <= {step_bit_c[ch], qm_q[ch][7:1]};
        n1q_q[ch] <= n1q_q[ch] + 4'(step_bit_c[ch]);
      end
    end else if (bal_c) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        if (de_q) begin
          tmds_q[ch] <= sym_c[ch];
          cnt_q[ch]  <= DC_BALANCE ? cnt_nx_c[ch] : 5'sd0;
        end else begin
          tmds_q[ch] <= ctl_sym((ch == 0) ? ctrl_q : 2'b00);
          cnt_q[ch]  <= 5'sd0;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel_x10) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= bal_c;
      if (capture_c)  busy <= 1'b1;
      else if (bal_c) busy <= 1'b0;
      if (start && state_q != S_IDLE) overrun <= 1'b1;
    end
  end

  assign tmds_internal0 = tmds_q[0];
  assign tmds_internal1 = tmds_q[1];
  assign tmds_internal2 = tmds_q[2];

endmodule
